// File: rtl/ctrl_mode_arbiter_if.sv
// Command-source arbitration bundle: strobes and requests in, source select and status out.
// The arbiter takes the slave side; the driving environment takes the master side.
interface ctrl_mode_arbiter_if;
   logic       f100_in;
   logic       isa_wr_strobe_in;
   logic       isa_req_in;
   logic       man_req_in;
   logic       selector_out;
   logic       safe_out;
   logic [1:0] mode_out;
   logic       wd_expired_out;
   logic [7:0] handover_cnt_out;

   modport master (
      output f100_in, isa_wr_strobe_in, isa_req_in, man_req_in,
      input  selector_out, safe_out, mode_out, wd_expired_out, handover_cnt_out
   );

   modport slave (
      input  f100_in, isa_wr_strobe_in, isa_req_in, man_req_in,
      output selector_out, safe_out, mode_out, wd_expired_out, handover_cnt_out
   );
endinterface

// File: rtl/ctrl_mode_arbiter.sv
// ISA/manual command-source arbiter with guarded handover, host watchdog and key debounce.
// Outputs registered (1 clock after the deciding input); no backpressure, all inputs sampled every cycle.
module ctrl_mode_arbiter #(
   parameter int unsigned WD_TICKS    = 50,
   parameter int unsigned GUARD_TICKS = 10,
   parameter int unsigned DEB_TICKS   = 3
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   ctrl_mode_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_MANUAL = 2'b00,
      ST_G2I    = 2'b01,
      ST_ISA    = 2'b10,
      ST_G2M    = 2'b11
   } state_t;

   localparam logic [7:0] WD_MAX   = 8'(WD_TICKS);
   localparam logic [7:0] GUARD_LD = 8'(GUARD_TICKS);
   localparam logic [3:0] DEB_LEN  = 4'(DEB_TICKS);

   state_t     state_q,  state_d;
   logic [7:0] wd_q,     wd_d;
   logic [7:0] guard_q,  guard_d;
   logic [7:0] hcnt_q,   hcnt_d;
   logic [3:0] run_q,    run_d;
   logic       man_db_q, man_db_d;
   logic       wd_exp_q, wd_exp_d;

   logic wd_ok;
   logic isa_drop;

   assign wd_ok    = (wd_q < WD_MAX);
   assign isa_drop = man_db_q || !bus.isa_req_in || !wd_ok;

   // Heartbeat clear beats the f100 increment so a coincident write keeps wd at zero.
   always_comb begin
      wd_d = wd_q;
      if (bus.isa_wr_strobe_in) begin
         wd_d = '0;
      end else if (bus.f100_in && (wd_q < WD_MAX)) begin
         wd_d = wd_q + 8'd1;
      end
   end

   always_comb begin
      man_db_d = man_db_q;
      run_d    = run_q;
      if (bus.f100_in) begin
         if (bus.man_req_in == man_db_q) begin
            run_d = '0;
         end else if ((run_q + 4'd1) >= DEB_LEN) begin
            man_db_d = ~man_db_q;
            run_d    = '0;
         end else begin
            run_d = run_q + 4'd1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      guard_d  = guard_q;
      hcnt_d   = hcnt_q;
      wd_exp_d = wd_exp_q;
      unique case (state_q)
         ST_MANUAL: begin
            if (bus.isa_req_in && !man_db_q && wd_ok) begin
               state_d = ST_G2I;
               guard_d = GUARD_LD;
            end
         end
         ST_G2I: begin
            if (isa_drop) begin
               state_d = ST_MANUAL;
               guard_d = '0;
            end else if (bus.f100_in) begin
               if (guard_q == 8'd1) begin
                  state_d  = ST_ISA;
                  guard_d  = '0;
                  hcnt_d   = hcnt_q + 8'd1;
                  wd_exp_d = 1'b0;
               end else begin
                  guard_d = guard_q - 8'd1;
               end
            end
         end
         ST_ISA: begin
            if (isa_drop) begin
               state_d = ST_G2M;
               guard_d = GUARD_LD;
               if (!wd_ok) begin
                  wd_exp_d = 1'b1;
               end
            end
         end
         ST_G2M: begin
            if (bus.f100_in) begin
               if (guard_q == 8'd1) begin
                  state_d = ST_MANUAL;
                  guard_d = '0;
                  hcnt_d  = hcnt_q + 8'd1;
               end else begin
                  guard_d = guard_q - 8'd1;
               end
            end
         end
         default: state_d = ST_MANUAL;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= ST_MANUAL;
         wd_q     <= WD_MAX;
         guard_q  <= '0;
         hcnt_q   <= '0;
         run_q    <= '0;
         man_db_q <= 1'b0;
         wd_exp_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wd_q     <= wd_d;
         guard_q  <= guard_d;
         hcnt_q   <= hcnt_d;
         run_q    <= run_d;
         man_db_q <= man_db_d;
         wd_exp_q <= wd_exp_d;
      end
   end

   // Selector only moves on guard boundaries, where safe is already high.
   assign bus.mode_out         = state_q;
   assign bus.selector_out     = (state_q == ST_ISA);
   assign bus.safe_out         = state_q[0];
   assign bus.wd_expired_out   = wd_exp_q;
   assign bus.handover_cnt_out = hcnt_q;

endmodule

// File: tb/tb_ctrl_mode_arbiter.sv
// Directed bench for ctrl_mode_arbiter: per-cycle check against an abstract model plus literal checkpoints.
module tb_ctrl_mode_arbiter;

   localparam int WD    = 50;
   localparam int GUARD = 10;
   localparam int DEB   = 3;

   localparam int M_MAN = 0;
   localparam int M_G2I = 1;
   localparam int M_ISA = 2;
   localparam int M_G2M = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   ctrl_mode_arbiter_if bus_if ();

   ctrl_mode_arbiter #(
      .WD_TICKS    (WD),
      .GUARD_TICKS (GUARD),
      .DEB_TICKS   (DEB)
   ) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .bus    (bus_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: source mode, strobes since last heartbeat, debounced key,
   // consecutive disagreeing samples, strobes seen in the current guard.
   int m_mode  = M_MAN;
   int m_since = WD;
   int m_man   = 0;
   int m_dis   = 0;
   int m_seen  = 0;
   int m_exp   = 0;
   int m_hand  = 0;

   always @(posedge clk or negedge rst_n) begin : model
      int nm, nseen, nexp, nh, ns, nman, ndis;
      bit ok, drop;
      if (!rst_n) begin
         m_mode  <= M_MAN;
         m_since <= WD;
         m_man   <= 0;
         m_dis   <= 0;
         m_seen  <= 0;
         m_exp   <= 0;
         m_hand  <= 0;
      end else begin
         nm    = m_mode;
         nseen = m_seen;
         nexp  = m_exp;
         nh    = m_hand;
         ok    = (m_since < WD);
         drop  = (m_man != 0) || !bus_if.isa_req_in || !ok;
         case (m_mode)
            M_MAN: if (bus_if.isa_req_in && m_man == 0 && ok) begin
               nm = M_G2I; nseen = 0;
            end
            M_G2I: if (drop) begin
               nm = M_MAN;
            end else if (bus_if.f100_in) begin
               nseen = m_seen + 1;
               if (nseen == GUARD) begin
                  nm = M_ISA; nexp = 0; nh = (m_hand + 1) % 256;
               end
            end
            M_ISA: if (drop) begin
               nm = M_G2M; nseen = 0;
               if (!ok) nexp = 1;
            end
            default: if (bus_if.f100_in) begin
               nseen = m_seen + 1;
               if (nseen == GUARD) begin
                  nm = M_MAN; nh = (m_hand + 1) % 256;
               end
            end
         endcase
         ns = m_since;
         if (bus_if.isa_wr_strobe_in) ns = 0;
         else if (bus_if.f100_in && ns < WD) ns = ns + 1;
         nman = m_man;
         ndis = m_dis;
         if (bus_if.f100_in) begin
            if (int'(bus_if.man_req_in) != m_man) begin
               ndis = ndis + 1;
               if (ndis == DEB) begin
                  nman = 1 - m_man; ndis = 0;
               end
            end else begin
               ndis = 0;
            end
         end
         m_mode  <= nm;
         m_seen  <= nseen;
         m_exp   <= nexp;
         m_hand  <= nh;
         m_since <= ns;
         m_man   <= nman;
         m_dis   <= ndis;
      end
   end

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic compare_model();
      logic [12:0] act, req;
      logic [1:0]  em;
      em  = m_mode[1:0];
      act = {bus_if.mode_out, bus_if.selector_out, bus_if.safe_out,
             bus_if.wd_expired_out, bus_if.handover_cnt_out};
      req = {em, (m_mode == M_ISA), em[0], (m_exp != 0), m_hand[7:0]};
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL model_cycle: got mode/sel/safe/exp/cnt=%b, expected %b (t=%0t)", act, req, $time);
      end
   endtask

   task automatic cyc(input bit f, input bit hb);
      @(negedge clk);
      compare_model();
      bus_if.f100_in          = f;
      bus_if.isa_wr_strobe_in = hb;
   endtask

   task automatic strobe(input bit hb);
      repeat (3) cyc(1'b0, 1'b0);
      cyc(1'b1, hb);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_mode"}, int'(bus_if.mode_out), 0);
      check({tag, "_sel"},  int'(bus_if.selector_out), 0);
      check({tag, "_safe"}, int'(bus_if.safe_out), 0);
      check({tag, "_exp"},  int'(bus_if.wd_expired_out), 0);
      check({tag, "_cnt"},  int'(bus_if.handover_cnt_out), 0);
   endtask

   initial begin
      bus_if.f100_in          = 1'b0;
      bus_if.isa_wr_strobe_in = 1'b0;
      bus_if.isa_req_in       = 1'b0;
      bus_if.man_req_in       = 1'b0;

      // Reset and no grant before the first heartbeat
      repeat (3) cyc(1'b0, 1'b0);
      check_reset_vals("rst");
      #2 rst_n = 1'b1;
      bus_if.isa_req_in = 1'b1;
      repeat (2) strobe(1'b0);
      cyc(1'b0, 1'b0);
      check("no_grant_wo_hb", int'(bus_if.mode_out), 0);

      // First grant
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      check("g2i_entry_mode", int'(bus_if.mode_out), 1);
      check("g2i_entry_safe", int'(bus_if.safe_out), 1);
      repeat (GUARD - 1) strobe(1'b0);
      cyc(1'b0, 1'b0);
      check("g2i_after9_mode", int'(bus_if.mode_out), 1);
      strobe(1'b0);
      cyc(1'b0, 1'b0);
      check("isa_mode", int'(bus_if.mode_out), 2);
      check("isa_sel",  int'(bus_if.selector_out), 1);
      check("isa_safe", int'(bus_if.safe_out), 0);
      check("isa_cnt",  int'(bus_if.handover_cnt_out), 1);

      // Watchdog trip after WD silent strobes
      cyc(1'b0, 1'b1);
      repeat (WD - 1) strobe(1'b0);
      cyc(1'b0, 1'b0);
      check("wd_49_mode", int'(bus_if.mode_out), 2);
      strobe(1'b0);
      cyc(1'b0, 1'b0);
      check("wd_trip_edge_mode", int'(bus_if.mode_out), 2);
      cyc(1'b0, 1'b0);
      check("wd_g2m_mode", int'(bus_if.mode_out), 3);
      check("wd_g2m_exp",  int'(bus_if.wd_expired_out), 1);
      check("wd_g2m_safe", int'(bus_if.safe_out), 1);
      repeat (GUARD - 1) strobe(1'b0);
      cyc(1'b0, 1'b0);
      check("g2m_after9_mode", int'(bus_if.mode_out), 3);
      strobe(1'b0);
      cyc(1'b0, 1'b0);
      check("man_mode", int'(bus_if.mode_out), 0);
      check("man_cnt",  int'(bus_if.handover_cnt_out), 2);
      check("man_exp_sticky", int'(bus_if.wd_expired_out), 1);

      // Re-grant clears the sticky flag on entry to ISA
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      check("regrant_g2i_mode", int'(bus_if.mode_out), 1);
      check("regrant_g2i_exp",  int'(bus_if.wd_expired_out), 1);
      repeat (GUARD) strobe(1'b1);
      cyc(1'b0, 1'b0);
      check("regrant_isa_mode", int'(bus_if.mode_out), 2);
      check("regrant_isa_exp",  int'(bus_if.wd_expired_out), 0);
      check("regrant_isa_cnt",  int'(bus_if.handover_cnt_out), 3);

      // Debounce: short pulse ignored, full run forces manual handover
      bus_if.man_req_in = 1'b1;
      repeat (DEB - 1) strobe(1'b1);
      bus_if.man_req_in = 1'b0;
      strobe(1'b1);
      cyc(1'b0, 1'b0);
      check("deb_short_mode", int'(bus_if.mode_out), 2);
      bus_if.man_req_in = 1'b1;
      repeat (DEB - 1) strobe(1'b1);
      cyc(1'b0, 1'b0);
      check("deb_2of3_mode", int'(bus_if.mode_out), 2);
      strobe(1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      check("deb_g2m_mode", int'(bus_if.mode_out), 3);
      check("deb_g2m_exp",  int'(bus_if.wd_expired_out), 0);
      bus_if.man_req_in = 1'b0;
      bus_if.isa_req_in = 1'b0;
      repeat (GUARD - 1) strobe(1'b1);
      cyc(1'b0, 1'b0);
      check("deb_g2m_hold", int'(bus_if.mode_out), 3);
      strobe(1'b1);
      cyc(1'b0, 1'b0);
      check("deb_man_mode", int'(bus_if.mode_out), 0);
      check("deb_man_cnt",  int'(bus_if.handover_cnt_out), 4);

      // Abort of GUARD_TO_ISA at strobe 5
      bus_if.isa_req_in = 1'b1;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      check("abort_g2i_mode", int'(bus_if.mode_out), 1);
      repeat (4) strobe(1'b1);
      repeat (3) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
      bus_if.isa_req_in = 1'b0;
      cyc(1'b0, 1'b0);
      check("abort_mode", int'(bus_if.mode_out), 0);
      check("abort_safe", int'(bus_if.safe_out), 0);
      check("abort_cnt",  int'(bus_if.handover_cnt_out), 4);

      // Heartbeat coincident with every strobe holds ISA
      bus_if.isa_req_in = 1'b1;
      repeat (300) strobe(1'b1);
      cyc(1'b0, 1'b0);
      check("coinc_mode", int'(bus_if.mode_out), 2);
      check("coinc_exp",  int'(bus_if.wd_expired_out), 0);
      check("coinc_cnt",  int'(bus_if.handover_cnt_out), 5);

      // Asynchronous reset in GUARD_TO_MAN
      bus_if.isa_req_in = 1'b0;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      check("pre_rst_mode", int'(bus_if.mode_out), 3);
      repeat (4) strobe(1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      compare_model();
      repeat (2) cyc(1'b0, 1'b0);
      #2 rst_n = 1'b1;
      bus_if.isa_req_in = 1'b1;
      repeat (3) strobe(1'b0);
      cyc(1'b0, 1'b0);
      check("post_rst_no_grant", int'(bus_if.mode_out), 0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      check("post_rst_grant", int'(bus_if.mode_out), 1);
      repeat (3) cyc(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
